// File: rtl/bcd_pkg.sv
// Types and constants shared by the BCD <-> binary converters.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        SCALE,
        DONE
    } b2b_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One digit of reverse double-dabble: after a right shift, a digit of 8 or more
// picked up a borrowed 8 that really stands for 5, so it is reduced by 3.
module bcd_digit_adjust (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd8) ? (i_digit - 4'd3) : i_digit;

endmodule

// File: rtl/bcd_to_binary.sv
// Packed BCD digits plus a decimal exponent -> saturating unsigned binary value.
// Reverse double-dabble (one bit per cycle), then one x10 per cycle.
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int BINARY_WIDTH = 24,
    parameter int EXP_WIDTH    = 3
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_start,
    input  logic [3:0]              i_bcd_in [NUM_DIGITS],
    input  logic [EXP_WIDTH-1:0]    i_scale_exp,
    output logic [BINARY_WIDTH-1:0] o_binary_out,
    output logic                    o_busy,
    output logic                    o_done_flag,
    output logic                    o_invalid_flag,
    output logic                    o_overflow_flag
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int IDX_W = $clog2(BCD_W + 1);
    localparam int PRD_W = BINARY_WIDTH + 4;

    b2b_state_t              r_state, r_state_next;
    logic [BCD_W-1:0]        r_bcd_shift, r_bcd_shift_next;
    logic [BCD_W-1:0]        r_bin_shift, r_bin_shift_next;
    logic [IDX_W-1:0]        r_index, r_index_next;
    logic [EXP_WIDTH-1:0]    r_exp, r_exp_next;
    logic [BINARY_WIDTH-1:0] r_acc, r_acc_next;
    logic [BINARY_WIDTH-1:0] r_binary_out, r_binary_out_next;
    logic                    r_done, r_done_next;
    logic                    r_invalid, r_invalid_next;
    logic                    r_overflow, r_overflow_next;

    logic [BCD_W-1:0]        w_bcd_packed;
    logic [NUM_DIGITS-1:0]   w_digit_bad;
    logic [BCD_W-1:0]        w_bcd_shr;
    logic [BCD_W-1:0]        w_bcd_adj;
    logic [BCD_W-1:0]        w_bin_shr;
    logic [PRD_W-1:0]        w_acc_ext;
    logic [PRD_W-1:0]        w_product;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_bcd_packed[4*gi +: 4] = i_bcd_in[gi];
            assign w_digit_bad[gi]         = (i_bcd_in[gi] > BCD_MAX);

            bcd_digit_adjust u_adjust (
                .i_digit (w_bcd_shr[4*gi +: 4]),
                .o_digit (w_bcd_adj[4*gi +: 4])
            );
        end
    endgenerate

    // The BCD and binary registers form one long shift register.
    assign w_bcd_shr = r_bcd_shift >> 1;
    assign w_bin_shr = {r_bcd_shift[0], r_bin_shift[BCD_W-1:1]};

    assign w_acc_ext = PRD_W'(r_acc);
    assign w_product = (w_acc_ext << 3) + (w_acc_ext << 1);

    always_comb begin
        r_state_next      = r_state;
        r_bcd_shift_next  = r_bcd_shift;
        r_bin_shift_next  = r_bin_shift;
        r_index_next      = r_index;
        r_exp_next        = r_exp;
        r_acc_next        = r_acc;
        r_binary_out_next = r_binary_out;
        r_done_next       = 1'b0;
        r_invalid_next    = r_invalid;
        r_overflow_next   = r_overflow;

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    if (|w_digit_bad) begin
                        r_binary_out_next = '0;
                        r_acc_next        = '0;
                        r_invalid_next    = 1'b1;
                        r_overflow_next   = 1'b0;
                        r_state_next      = DONE;
                    end else begin
                        r_bcd_shift_next = w_bcd_packed;
                        r_bin_shift_next = '0;
                        r_index_next     = IDX_W'(BCD_W);
                        r_exp_next       = i_scale_exp;
                        r_invalid_next   = 1'b0;
                        r_overflow_next  = 1'b0;
                        r_state_next     = CONVERT;
                    end
                end
            end

            CONVERT: begin
                r_bcd_shift_next = w_bcd_adj;
                r_bin_shift_next = w_bin_shr;
                r_index_next     = r_index - IDX_W'(1);
                if (r_index == IDX_W'(1)) begin
                    r_acc_next   = BINARY_WIDTH'(w_bin_shr);
                    r_state_next = (r_exp != '0) ? SCALE : DONE;
                end
            end

            SCALE: begin
                // Any bit above BINARY_WIDTH means the x10 overflowed.
                if (w_product[PRD_W-1:BINARY_WIDTH] != '0) begin
                    r_acc_next      = '1;
                    r_overflow_next = 1'b1;
                    r_state_next    = DONE;
                end else begin
                    r_acc_next = w_product[BINARY_WIDTH-1:0];
                    r_exp_next = r_exp - EXP_WIDTH'(1);
                    if (r_exp == EXP_WIDTH'(1)) begin
                        r_state_next = DONE;
                    end
                end
            end

            DONE: begin
                r_binary_out_next = r_invalid ? '0 : r_acc;
                r_done_next       = 1'b1;
                r_state_next      = IDLE;
            end

            default: r_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_bcd_shift  <= '0;
            r_bin_shift  <= '0;
            r_index      <= '0;
            r_exp        <= '0;
            r_acc        <= '0;
            r_binary_out <= '0;
            r_done       <= 1'b0;
            r_invalid    <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= r_state_next;
            r_bcd_shift  <= r_bcd_shift_next;
            r_bin_shift  <= r_bin_shift_next;
            r_index      <= r_index_next;
            r_exp        <= r_exp_next;
            r_acc        <= r_acc_next;
            r_binary_out <= r_binary_out_next;
            r_done       <= r_done_next;
            r_invalid    <= r_invalid_next;
            r_overflow   <= r_overflow_next;
        end
    end

    assign o_binary_out    = r_binary_out;
    assign o_busy          = (r_state != IDLE);
    assign o_done_flag     = r_done;
    assign o_invalid_flag  = r_invalid;
    assign o_overflow_flag = r_overflow;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed and randomized checks of bcd_to_binary against an arithmetic reference model.
module tb_bcd_to_binary;

    localparam int  ND     = 4;
    localparam int  BW     = 24;
    localparam int  EW     = 3;
    localparam longint MAXV = (64'd1 << BW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [3:0]    bcd [ND];
    logic [EW-1:0] sexp;
    logic [BW-1:0] binary_out;
    logic          busy, done_flag, invalid_flag, overflow_flag;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    bcd_to_binary #(
        .NUM_DIGITS   (ND),
        .BINARY_WIDTH (BW),
        .EXP_WIDTH    (EW)
    ) dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_start         (start),
        .i_bcd_in        (bcd),
        .i_scale_exp     (sexp),
        .o_binary_out    (binary_out),
        .o_busy          (busy),
        .o_done_flag     (done_flag),
        .o_invalid_flag  (invalid_flag),
        .o_overflow_flag (overflow_flag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic longint pow10(input int n);
        longint p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    // Reference: decimal value of the digits times 10^exp, saturating on the first
    // multiply that leaves the result range; invalid digits short-circuit to 0.
    task automatic model(input logic [15:0] b, input int e,
                         output longint val, output bit inv, output bit ovf, output int lat);
        int k;
        inv = 1'b0;
        for (int i = 0; i < ND; i++) if (b[4*i +: 4] > 4'd9) inv = 1'b1;
        ovf = 1'b0;
        val = 0;
        if (inv) begin
            lat = 1;
        end else begin
            for (int i = 0; i < ND; i++) val += longint'(b[4*i +: 4]) * pow10(i);
            k = 0;
            while (k < e) begin
                val = val * 10;
                k++;
                if (val > MAXV) begin
                    val = MAXV;
                    ovf = 1'b1;
                    break;
                end
            end
            lat = 4 * ND + k + 1;
        end
    endtask

    // One conversion; glitch_at > 0 pulses start with junk that many cycles in.
    task automatic do_conv(input string tag, input logic [15:0] b, input int e,
                           input int glitch_at, output logic [BW-1:0] result);
        longint mval;
        bit     minv, movf;
        int     mlat, cyc;
        model(b, e, mval, minv, movf, mlat);
        @(negedge clk);
        for (int i = 0; i < ND; i++) bcd[i] = b[4*i +: 4];
        sexp  = EW'(e);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < ND; i++) bcd[i] = 4'($urandom_range(0, 15));
        sexp = EW'($urandom);
        cyc = 0;
        while (!done_flag && cyc < 60) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
            if (cyc == glitch_at) begin
                for (int i = 0; i < ND; i++) bcd[i] = 4'd9;
                sexp  = 3'd7;
                start = 1'b1;
            end
        end
        result = binary_out;
        if (!done_flag) check({tag, ".timeout"}, 32'd0, 32'd1);
        check({tag, ".latency"},  32'(cyc),           32'(mlat));
        check({tag, ".binary"},   32'(binary_out),    32'(mval));
        check({tag, ".invalid"},  32'(invalid_flag),  32'(minv));
        check({tag, ".overflow"}, 32'(overflow_flag), 32'(movf));
        check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, ".done_pulse"}, 32'(done_flag), 32'd0);
        $display("%s bcd=%h exp=%0d -> out=%0d inv=%0b ovf=%0b lat=%0d",
                 tag, b, e, binary_out, invalid_flag, overflow_flag, cyc);
    endtask

    initial begin
        logic [BW-1:0] res;
        logic [15:0]   b;
        int            e, v, x, dones;
        longint        trunc;

        rst_n = 1'b0;
        start = 1'b0;
        sexp  = '0;
        for (int i = 0; i < ND; i++) bcd[i] = 4'd0;
        #12;
        check("reset.binary",   32'(binary_out),    32'd0);
        check("reset.busy",     32'(busy),          32'd0);
        check("reset.done",     32'(done_flag),     32'd0);
        check("reset.invalid",  32'(invalid_flag),  32'd0);
        check("reset.overflow", 32'(overflow_flag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_conv("t1_1234",      16'h1234, 0, 0, res);
        do_conv("t2_999e3",     16'h0999, 3, 0, res);
        do_conv("t3_sat",       16'h9999, 7, 0, res);
        do_conv("t4_invalid",   16'h1A00, 0, 0, res);
        do_conv("t4b_recover",  16'h0001, 7, 0, res);
        do_conv("t5_zero",      16'h0000, 7, 0, res);
        do_conv("t5_glitch",    16'h0042, 1, 5, res);

        // Abort mid-CONVERT: outputs clear at once and no done follows.
        @(negedge clk);
        bcd[3] = 4'd5; bcd[2] = 4'd6; bcd[1] = 4'd7; bcd[0] = 4'd8;
        sexp  = 3'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("abort.binary",  32'(binary_out), 32'd0);
        check("abort.busy",    32'(busy),       32'd0);
        check("abort.invalid", 32'(invalid_flag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done_flag) dones++;
        end
        check("abort.no_done", 32'(dones), 32'd0);
        $display("abort mid-convert dones=%0d", dones);

        // Random digits (occasionally invalid) and random exponents.
        for (int n = 0; n < 150; n++) begin
            b = 16'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                for (int i = 0; i < ND; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            e = $urandom_range(0, 7);
            do_conv("rand", b, e, 0, res);
        end

        // Round trip: autoscale x to 4 significant digits, convert back.
        for (int n = 0; n < 1000; n++) begin
            x = int'($urandom_range(0, 32'(MAXV)));
            v = x;
            e = 0;
            while (v > 9999) begin
                v = v / 10;
                e++;
            end
            for (int i = 0; i < ND; i++) b[4*i +: 4] = 4'((v / int'(pow10(i))) % 10);
            do_conv("roundtrip", b, e, 0, res);
            trunc = longint'(x) - (longint'(x) % pow10(e));
            check("roundtrip.truncated", 32'(res), 32'(trunc));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
